// File: rtl/aes_sbox_array.sv
// aes_sbox_array: registered forward/inverse AES S-box over LANES byte lanes with valid/ready flow control
module aes_sbox_array #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_inv,
    output logic [CNT_W-1:0]     xfer_cnt
);
    localparam logic [7:0] FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    localparam logic [7:0] INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
    logic [8*LANES-1:0] sub, data_q, data_d;
    logic               valid_q, valid_d, inv_q, inv_d, accept;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sub[8*i +: 8] = in_inv ? INV[in_data[8*i +: 8]] : FWD[in_data[8*i +: 8]];
    end
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_inv   = inv_q;
    assign xfer_cnt  = cnt_q;
    // accept loads a new result (even while draining); a drain without accept only clears valid
    always_comb begin
        accept  = in_valid && in_ready;
        valid_d = accept || (valid_q && !out_ready);
        data_d  = accept ? sub : data_q;
        inv_d   = accept ? in_inv : inv_q;
        cnt_d   = accept ? cnt_q + CNT_W'(1) : cnt_q;
    end
    // output register stage; reset discards any held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_aes_sbox_array.sv
// tb_aes_sbox_array: randomized scoreboard bench against a GF(2^8) reference S-box
module tb_aes_sbox_array;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_inv;
    logic [31:0] out_data;
    logic [15:0] xfer_cnt;
    logic         in_valid16 = 1'b0, in_inv16 = 1'b0, out_ready16 = 1'b1;
    logic [127:0] in_data16 = '0;
    logic         in_ready16, out_valid16, out_inv16;
    logic [127:0] out_data16;
    logic [3:0]   xfer_cnt16;

    aes_sbox_array #(.LANES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inv(out_inv), .xfer_cnt(xfer_cnt));
    aes_sbox_array #(.LANES(16), .CNT_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .in_inv(in_inv16), .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
        .out_inv(out_inv16), .xfer_cnt(xfer_cnt16));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            b = b >> 1;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = inv ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [31:0] data; logic inv; } exp_t;
    exp_t sb[$];
    int   exp_cnt = 0;
    logic stall = 1'b0;
    logic [32:0] held;

    // monitor: checks handshake, count and held data, pops at drain, pushes at accept
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_cnt = 0;
            stall = 1'b0;
        end else begin
            exp_t e;
            chk("in_ready", {127'b0, in_ready}, {127'b0, !out_valid || out_ready});
            chk("xfer_cnt", {112'b0, xfer_cnt}, {112'b0, exp_cnt[15:0]});
            if (stall) chk("hold", {94'b0, out_valid, out_inv, out_data}, {94'b0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", {127'b0, out_valid}, 128'b0);
                else begin
                    e = sb.pop_front();
                    chk("sb_data", {96'b0, out_data}, {96'b0, e.data});
                    chk("sb_inv", {127'b0, out_inv}, {127'b0, e.inv});
                end
            end
            stall = out_valid && !out_ready;
            held = {out_inv, out_data};
            if (in_valid && in_ready) begin
                sb.push_back('{data: model(in_data, in_inv), inv: in_inv});
                exp_cnt++;
            end
        end
    end

    initial begin
        logic [31:0] x4, first, second;
        logic [15:0] snap;
        logic acc;
        int n;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] b = 0;
            if (a != 0) for (int c = 1; c < 256; c++) if (gmul(8'(a), 8'(c)) == 8'h01) b = 8'(c);
            fwd_t[a] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) inv_t[fwd_t[a]] = 8'(a);
        #3;
        chk("rst_valid", {127'b0, out_valid}, 128'b0);
        chk("rst_data", {96'b0, out_data}, 128'b0);
        chk("rst_inv", {127'b0, out_inv}, 128'b0);
        chk("rst_cnt", {112'b0, xfer_cnt}, 128'b0);
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", {127'b0, in_ready}, 128'd1);
        // directed vectors
        in_valid = 1; in_data = 32'hFF53_0100; in_inv = 0;
        cyc();
        chk("vec_fwd", {95'b0, out_valid, out_inv, out_data}, {95'b0, 1'b1, 1'b0, 32'h16ED_7C63});
        chk("vec_cnt", {112'b0, xfer_cnt}, 128'd1);
        in_data = 32'h16ED_7C63; in_inv = 1;
        cyc();
        chk("vec_inv", {96'b0, out_data}, {96'b0, 32'hFF53_0100});
        in_data = 32'h0; in_inv = 1;
        cyc();
        chk("vec_zero_inv", {96'b0, out_data}, {96'b0, 32'h5252_5252});
        // exhaustive round trip: DUT forward result fed straight back inverted
        for (int x = 0; x < 256; x++) begin
            x4 = {8'(x + 3), 8'(x + 2), 8'(x + 1), 8'(x)};
            in_data = x4; in_inv = 0;
            cyc();
            in_data = out_data; in_inv = 1;
            cyc();
            chk("round_trip", {95'b0, out_valid, out_inv, out_data}, {95'b0, 1'b1, 1'b1, x4});
        end
        // randomized traffic with upstream hold while not ready
        in_valid = 0;
        for (n = 0; n < 400; n++) begin
            acc = in_valid && in_ready;
            cyc();
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_data = $urandom;
                in_inv = 1'($urandom);
            end
            out_ready = $urandom_range(0, 2) != 0;
        end
        // backpressure for 5 cycles then release with a waiting transaction
        in_valid = 0; out_ready = 1;
        cyc(); cyc();
        first = 32'hA5A5_0F0F; second = 32'h1234_5678;
        out_ready = 0; in_valid = 1; in_data = first; in_inv = 0;
        cyc();
        snap = exp_cnt[15:0];
        chk("bp_first", {96'b0, out_data}, {96'b0, model(first, 0)});
        in_data = second; in_inv = 1;
        repeat (5) begin
            cyc();
            chk("bp_ready", {127'b0, in_ready}, 128'b0);
            chk("bp_data", {95'b0, out_valid, out_inv, out_data}, {95'b0, 1'b1, 1'b0, model(first, 0)});
            chk("bp_cnt", {112'b0, xfer_cnt}, {112'b0, snap});
        end
        out_ready = 1;
        cyc();
        in_valid = 0;
        chk("bp_swap", {95'b0, out_valid, out_inv, out_data}, {95'b0, 1'b1, 1'b1, model(second, 1)});
        chk("bp_swap_cnt", {112'b0, xfer_cnt}, {112'b0, snap + 16'd1});
        // asynchronous reset while holding a result
        out_ready = 0; in_valid = 1; in_data = $urandom; in_inv = 0;
        cyc();
        in_valid = 0;
        cyc();
        #2 rst_n = 0;
        #1;
        chk("arst_valid", {127'b0, out_valid}, 128'b0);
        chk("arst_data", {96'b0, out_data}, 128'b0);
        chk("arst_cnt", {112'b0, xfer_cnt}, 128'b0);
        cyc(); cyc();
        rst_n = 1; out_ready = 1; in_valid = 1; in_data = 32'h0102_0304; in_inv = 0;
        cyc();
        in_valid = 0;
        chk("post_rst", {96'b0, out_data}, {96'b0, model(32'h0102_0304, 0)});
        chk("post_rst_cnt", {112'b0, xfer_cnt}, 128'd1);
        // 16-lane FIPS-197 round-1 SubBytes and 4-bit counter wrap
        in_valid16 = 1; in_inv16 = 0;
        in_data16 = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
        cyc();
        chk("fips_subbytes", out_data16, 128'h3052411e_e55db4b8_f198bfe0_ae1127d4);
        repeat (16) begin
            in_data16 = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        in_valid16 = 0;
        chk("cnt_wrap", {124'b0, xfer_cnt16}, 128'd1);
        // bounded drain of the scoreboard
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        chk("sb_empty", 128'(sb.size()), 128'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_sbox_array.md
Name: aes_sbox_array

Overview:
Parametrised, pipelined byte-substitution unit for the AES datapath. It applies the forward or inverse AES S-box to LANES bytes in parallel, with the direction chosen per transaction. A valid/ready handshake on both sides lets it feed SubBytes/InvSubBytes in the round logic and the key-expansion SubWord path. One unit serves both the encryption and decryption cores.

Parameters:
LANES, 4, number of byte lanes substituted per transaction (legal 1..16; 4 = one word, 16 = full state)
CNT_W, 16, width of the accepted-transaction counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  unit can accept a transaction this cycle
in_data  input  8*LANES  bytes to substitute; lane i = bits [8i+7:8i]
in_inv  input  1  0 = forward S-box, 1 = inverse S-box
out_valid  output  1  result held on out_data is valid
out_ready  input  1  downstream accepts the result this cycle
out_data  output  8*LANES  substituted bytes, lane-aligned with in_data
out_inv  output  1  direction tag of the transaction on out_data
xfer_cnt  output  CNT_W  count of accepted input transactions

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_inv=0, xfer_cnt=0. in_ready=1 once reset is released.
- Reset mid-operation drops any held result. No partial output is ever presented.
- Forward table is the FIPS-197 S-box. Inverse table is its exact inverse: inv(sbox(x))=x for all 256 x. Lookups are combinational per lane and independent of the other lanes.
- Single registered output stage. Latency is 1 cycle from input accept to out_valid.
- Input accept occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is a combinational pass-through of out_ready, so full throughput is 1 transaction/cycle.
- On accept: out_data <= per-lane substitution of in_data, using the in_inv of that same cycle; out_inv <= in_inv; out_valid <= 1.
- Output drain occurs when out_valid && out_ready. If there is no simultaneous accept, out_valid <= 0 and out_data/out_inv keep their last value.
- Simultaneous drain and accept: the new result replaces the old in the same edge and out_valid stays 1. No bubble, no loss.
- Backpressure (out_valid && !out_ready): in_ready=0. out_data, out_inv and out_valid are held stable until drained. in_data/in_inv are ignored.
- in_valid while in_ready=0: not accepted, no state change. The upstream source must hold the transaction.
- Direction can change every transaction with no penalty or flush.
- xfer_cnt increments by 1 on each accept and wraps from 2^CNT_W-1 to 0. It does not count drains.
- No X propagation: all 256 input codes are defined in both directions.

Test Plan:
- Reset, then LANES=4, in_data=32'hFF53_0100, in_inv=0, out_ready=1 → next cycle out_valid=1, out_data=32'h16ED_7C63, out_inv=0, xfer_cnt=1.
- Same port, in_data=32'h16ED_7C63, in_inv=1 → out_data=32'hFF53_0100. Also in_data=32'h0000_0000, inv=1 → 32'h5252_5252.
- Exhaustive round-trip: for each x in 0..255, forward then inverse in back-to-back cycles, with the direction alternating every cycle → every result returns x, one transaction per cycle, no bubbles.
- Backpressure: hold out_ready=0 for 5 cycles after one accept → in_ready=0, out_data stable. A second in_valid is not accepted and xfer_cnt stays unchanged. Release out_ready → the held result drains and the waiting transaction is accepted on the same edge.
- Assert rst_n low asynchronously while out_valid=1 under backpressure → out_valid, out_data and xfer_cnt go to 0 immediately, before the next clk edge. After release, the first result is correct.
- CNT_W=4: 17 accepts → xfer_cnt reads 1 (wrapped). LANES=16 build with the FIPS-197 Appendix B round-1 state → matches the SubBytes row in the standard.
